uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 8'd16: max consecutive bytes per grant (burst mode only); legal range 1..255.
REQ-002 Parameter HANDOFF_TMO, default 4'd4: cycles allowed for tx_empty to fall after a write.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 clear  input  1  synchronous soft clear, active-high.
REQ-006 enable  input  1  arbitration enable.
REQ-007 req_valid  input  4  per-requester byte available.
REQ-008 req_data  input  32  byte of requester i on bits [8i+7:8i].
REQ-009 req_ready  output  4  one-cycle pulse: requester i byte consumed.
REQ-010 tx_cyc, tx_cs, tx_wr  output  1 each  transmitter bus write strobes.
REQ-011 tx_din  output  8  byte to transmitter.
REQ-012 tx_ack  input  1  transmitter bus acknowledge.
REQ-013 tx_empty  input  1  transmitter holding register empty.
REQ-014 grant  output  2  index of current/last granted requester.
REQ-015 busy  output  1  high whenever state != IDLE.
REQ-016 err  output  1  sticky handoff-timeout flag.

Function
REQ-017 States: IDLE, WRITE, HANDOFF, DRAIN; registered, one transition max per cycle.
REQ-018 IDLE: when enable=1, tx_empty=1, and any req_valid, grant <= first valid index scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); -> WRITE.
REQ-019 WRITE: tx_cyc=tx_cs=tx_wr=1, tx_din=req_data[grant]; remains until tx_ack=1; in the tx_ack cycle req_ready[grant]=1 and -> HANDOFF.
REQ-020 Strobes and req_ready are zero in every state except WRITE; tx_wr is asserted for exactly one ack'd cycle per byte, then low at least one cycle (transmitter edge-detects writes).
REQ-021 HANDOFF: count cycles; tx_empty=0 -> DRAIN; count reaches HANDOFF_TMO with tx_empty still 1 -> err<=1, -> IDLE, ptr <= grant+1.
REQ-022 DRAIN: wait tx_empty=1; then burst-continue (REQ-030) -> WRITE same grant, else -> IDLE with ptr <= grant+1 (wraps 3->0).
REQ-023 At most one req_ready bit high per cycle; req_ready never asserted for an invalid requester.
REQ-024 enable deassert mid-byte: current byte completes through DRAIN; no new grant while enable=0.
REQ-025 req_valid dropping during WRITE before tx_ack: write still completes with sampled data; requester rules forbid this, no error flagged.
REQ-026 clear: next state IDLE, ptr=0, burst count=0, strobes low, err=0; clear overrides all transitions same cycle.
REQ-027 err cleared only by rst_n or clear.

Reset
REQ-028 rst_n low: state=IDLE, ptr=0, grant=0, burst count=0, err=0, busy=0, req_ready=0, tx_cyc/tx_cs/tx_wr=0, tx_din=8'h00, immediately (async).
REQ-029 Reset release synchronous to clk; first grant possible the first cycle after release.

Configuration
REQ-030 Macro UART_TX_ARB_BURST_EN defined: in DRAIN, if req_valid[grant]=1, enable=1, and bytes sent this grant < BURST_MAX, reissue WRITE to same grant; burst count resets on each new grant.
REQ-031 UART_TX_ARB_BURST_EN undefined: every byte returns to IDLE and rotates ptr; BURST_MAX ignored; no burst counter.

Verification
REQ-032 Reset: rst_n=0 mid-WRITE -> strobes, req_ready, busy drop same cycle; after release state IDLE, grant=0.
REQ-033 Round robin: req_valid=4'b1111 continuously, tx_empty model returns 1 four cycles after each write, burst off -> grant order 0,1,2,3,0; each req_ready one pulse per byte.
REQ-034 Skip: req_valid=4'b1010, ptr=0 -> grant=1 then 3 then 1; bytes 8'hA1/8'hA3 on tx_din in order.
REQ-035 Burst (UART_TX_ARB_BURST_EN, BURST_MAX=3): req_valid=4'b0011 held -> bytes from 0,0,0,1,1,1,0.
REQ-036 Timeout: tx_empty stuck 1 after write -> err=1 after 4 HANDOFF cycles, state IDLE, ptr advanced; clear=1 -> err=0.
REQ-037 Backpressure: tx_ack held low 5 cycles in WRITE -> tx_wr stays 1, req_ready stays 0, then one pulse on ack.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding four byte requesters into one UART transmitter.
// Define UART_TX_ARB_BURST_EN to let a grant keep the transmitter for up to BURST_MAX bytes.
module uart_tx_arbiter #(
    parameter logic [7:0] BURST_MAX   = 8'd16,
    parameter logic [3:0] HANDOFF_TMO = 4'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        tx_cyc,
    output logic        tx_cs,
    output logic        tx_wr,
    output logic [7:0]  tx_din,
    input  logic        tx_ack,
    input  logic        tx_empty,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        HANDOFF = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_ptr;
    logic [1:0]  r_grant;
    logic [3:0]  r_hcnt;
    logic        r_err;
    logic        r_strb;
    logic [7:0]  r_din;

    logic        w_hit;
    logic [1:0]  w_pick;
    logic [1:0]  w_idx;
    logic        w_cont;

    // Scan downward so the requester nearest the pointer wins.
    always_comb begin
        w_hit  = 1'b0;
        w_pick = r_ptr;
        w_idx  = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (req_valid[w_idx]) begin
                w_hit  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

`ifdef UART_TX_ARB_BURST_EN
    logic [7:0] r_bcnt;

    assign w_cont = req_valid[r_grant] && enable && (r_bcnt < BURST_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt <= 8'd0;
        end else if (clear) begin
            r_bcnt <= 8'd0;
        end else if (r_state == IDLE && enable && tx_empty && w_hit) begin
            r_bcnt <= 8'd1;
        end else if (r_state == DRAIN && tx_empty && w_cont) begin
            r_bcnt <= r_bcnt + 8'd1;
        end
    end
`else
    assign w_cont = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_grant <= 2'd0;
            r_hcnt  <= 4'd0;
            r_err   <= 1'b0;
            r_strb  <= 1'b0;
            r_din   <= 8'h00;
        end else if (clear) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_hcnt  <= 4'd0;
            r_err   <= 1'b0;
            r_strb  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (enable && tx_empty && w_hit) begin
                        r_grant <= w_pick;
                        r_din   <= req_data[{w_pick, 3'b000} +: 8];
                        r_strb  <= 1'b1;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (tx_ack) begin
                        r_strb  <= 1'b0;
                        r_hcnt  <= 4'd0;
                        r_state <= HANDOFF;
                    end
                end
                HANDOFF: begin
                    if (!tx_empty) begin
                        r_state <= DRAIN;
                    end else if (r_hcnt == HANDOFF_TMO - 4'd1) begin
                        r_err   <= 1'b1;
                        r_ptr   <= r_grant + 2'd1;
                        r_state <= IDLE;
                    end else begin
                        r_hcnt <= r_hcnt + 4'd1;
                    end
                end
                DRAIN: begin
                    if (tx_empty) begin
                        if (w_cont) begin
                            r_din   <= req_data[{r_grant, 3'b000} +: 8];
                            r_strb  <= 1'b1;
                            r_state <= WRITE;
                        end else begin
                            r_ptr   <= r_grant + 2'd1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_cyc    = r_strb;
    assign tx_cs     = r_strb;
    assign tx_wr     = r_strb;
    assign tx_din    = r_din;
    assign grant     = r_grant;
    assign busy      = (r_state != IDLE);
    assign err       = r_err;
    assign req_ready = (r_strb && tx_ack && req_valid[r_grant])
                     ? (4'b0001 << r_grant) : 4'b0000;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model.
// Burst ordering is checked when UART_TX_ARB_BURST_EN is defined.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  req_valid = 4'b0000;
    logic [31:0] req_data = 32'hA3A2A1A0;
    logic [3:0]  req_ready;
    logic        tx_cyc, tx_cs, tx_wr;
    logic [7:0]  tx_din;
    logic        tx_ack;
    logic        tx_empty;
    logic [1:0]  grant;
    logic        busy;
    logic        err;

    logic        ack_en = 1'b1;
    logic        stuck = 1'b0;
    logic        m_empty = 1'b1;
    logic [2:0]  m_cnt = 3'd0;

    int total = 0;
    int bad = 0;

    uart_tx_arbiter #(.BURST_MAX(8'd3), .HANDOFF_TMO(4'd4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tx_cyc(tx_cyc), .tx_cs(tx_cs), .tx_wr(tx_wr), .tx_din(tx_din),
        .tx_ack(tx_ack), .tx_empty(tx_empty), .grant(grant),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Transmitter: acks immediately, goes non-empty, empties 4 cycles later.
    assign tx_ack   = tx_wr & ack_en;
    assign tx_empty = m_empty;

    always @(posedge clk) begin
        if (tx_wr && tx_ack && !stuck) begin
            m_empty <= 1'b0;
            m_cnt   <= 3'd4;
        end else if (m_cnt != 3'd0) begin
            m_cnt <= m_cnt - 3'd1;
            if (m_cnt == 3'd1) m_empty <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wr(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx_wr) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_clear;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    logic [1:0] rr_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] sk_seq [3] = '{2'd1, 2'd3, 2'd1};
`ifdef UART_TX_ARB_BURST_EN
    logic [1:0] bu_seq [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
`else
    logic [1:0] bu_seq [3] = '{2'd0, 2'd1, 2'd0};
`endif

    initial begin
        bit ok;
        logic seen;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr", 32'(tx_wr), 32'd0);
        chk("rst_cyc", 32'(tx_cyc), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_din", 32'(tx_din), 32'h00);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Round robin over all four requesters
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ready(ok);
            chk("rr_seen", 32'(ok), 32'd1);
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << rr_seq[i]));
            chk("rr_grant", 32'(grant), 32'(rr_seq[i]));
            chk("rr_din", 32'(tx_din), 32'(8'hA0 + 8'(rr_seq[i])));
            chk("rr_cs", 32'(tx_cs), 32'd1);
            @(negedge clk);
            chk("rr_pulse", 32'(req_ready), 32'd0);
            chk("rr_wr_low", 32'(tx_wr), 32'd0);
        end
        req_valid = 4'b0000;
        wait_idle(ok);
        chk("rr_idle", 32'(ok), 32'd1);

        // Clear rewinds the pointer; sparse requesters are skipped
        pulse_clear();
        chk("clr_err", 32'(err), 32'd0);
        req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            wait_ready(ok);
            chk("sk_seen", 32'(ok), 32'd1);
            chk("sk_grant", 32'(grant), 32'(sk_seq[i]));
            chk("sk_din", 32'(tx_din), 32'(8'hA0 + 8'(sk_seq[i])));
        end
        req_valid = 4'b0000;
        wait_idle(ok);
        chk("sk_idle", 32'(ok), 32'd1);

        // Backpressure: ack withheld for five cycles
        ack_en    = 1'b0;
        req_valid = 4'b0001;
        wait_wr(ok);
        chk("bp_wr_seen", 32'(ok), 32'd1);
        chk("bp_grant", 32'(grant), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_wr_hold", 32'(tx_wr), 32'd1);
            chk("bp_no_ready", 32'(req_ready), 32'd0);
            if (i < 4) @(negedge clk);
        end
        ack_en = 1'b1;
        #1;
        chk("bp_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = 4'b0000;
        chk("bp_ready_off", 32'(req_ready), 32'd0);
        chk("bp_wr_off", 32'(tx_wr), 32'd0);
        wait_idle(ok);
        chk("bp_idle", 32'(ok), 32'd1);

        // No new grant while disabled
        enable    = 1'b0;
        req_valid = 4'b1111;
        seen      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | busy | tx_wr;
        end
        chk("en_off", 32'(seen), 32'd0);
        req_valid = 4'b0000;
        enable    = 1'b1;

        // Handoff timeout: transmitter never leaves empty
        stuck     = 1'b1;
        req_valid = 4'b0100;
        wait_ready(ok);
        req_valid = 4'b0000;
        chk("to_seen", 32'(ok), 32'd1);
        chk("to_grant", 32'(grant), 32'd2);
        repeat (4) @(negedge clk);
        chk("to_err_early", 32'(err), 32'd0);
        chk("to_busy_early", 32'(busy), 32'd1);
        @(negedge clk);
        chk("to_err", 32'(err), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        stuck     = 1'b0;
        req_valid = 4'b1111;
        wait_ready(ok);
        req_valid = 4'b0000;
        chk("to_ptr", 32'(grant), 32'd3);
        chk("to_sticky", 32'(err), 32'd1);
        wait_idle(ok);
        pulse_clear();
        chk("to_clear", 32'(err), 32'd0);

        // Burst ordering (or strict rotation without bursts)
        req_valid = 4'b0011;
        for (int i = 0; i < $size(bu_seq); i++) begin
            wait_ready(ok);
            if (i == $size(bu_seq) - 1) req_valid = 4'b0000;
            chk("bu_seen", 32'(ok), 32'd1);
            chk("bu_grant", 32'(grant), 32'(bu_seq[i]));
        end
        wait_idle(ok);
        chk("bu_idle", 32'(ok), 32'd1);
        pulse_clear();

        // Async reset in the middle of a write
        ack_en    = 1'b0;
        req_valid = 4'b0100;
        wait_wr(ok);
        chk("ar_wr_seen", 32'(ok), 32'd1);
        ack_en = 1'b1;
        #1;
        chk("ar_ready_pre", 32'(req_ready), 32'b0100);
        rst_n = 1'b0;
        #1;
        chk("ar_wr", 32'(tx_wr), 32'd0);
        chk("ar_ready", 32'(req_ready), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        req_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_grant", 32'(grant), 32'd0);
        chk("ar_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
